// File: rtl/powlib_edge_decode_if.sv
// powlib_edge_decode_if
//   Bundle for the edge-event decoder.
//   - Event side: pos/neg edge pulses, vld qualifier and clr.
//   - Result side: reconstructed levels q, qvld, err pulses,
//     err_sticky and the saturating violation counter errcnt.
//   - master: drives the events and observes the results.
//   - slave:  the decoder itself.
interface powlib_edge_decode_if #(
  parameter int W  = 1,
  parameter int CW = 8
);
  logic [W-1:0]  pos;
  logic [W-1:0]  neg;
  logic          vld;
  logic          clr;
  logic [W-1:0]  q;
  logic          qvld;
  logic [W-1:0]  err;
  logic [W-1:0]  err_sticky;
  logic [CW-1:0] errcnt;

  modport master (
    output pos, neg, vld, clr,
    input  q, qvld, err, err_sticky, errcnt
  );

  modport slave (
    input  pos, neg, vld, clr,
    output q, qvld, err, err_sticky, errcnt
  );
endinterface

// File: rtl/powlib_edge_decode.sv
// powlib_edge_decode
//   Rebuilds a W-bit level vector from per-bit rising/falling edge pulses.
//   Also flags protocol violations per bit:
//   - a rise while already high,
//   - a fall while already low,
//   - rise and fall in the same cycle.
//   Keeps a sticky per-bit violation record and a saturating count of
//   violating cycles.
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous reset, active-low
//   ev   : powlib_edge_decode_if.slave
//          in : pos, neg, vld, clr
//          out: q, qvld, err, err_sticky, errcnt (all registered)
// Parameters
//   W    : vector width
//   INIT : reset value of q
//   EVLD : 1 = events qualified by vld, 0 = always sampled
//   EERR : 1 = violation logic present, 0 = err/err_sticky/errcnt stay 0
//   CW   : errcnt width (saturating)
module powlib_edge_decode #(
  parameter int           W    = 1,
  parameter logic [W-1:0] INIT = '0,
  parameter bit           EVLD = 1'b0,
  parameter bit           EERR = 1'b1,
  parameter int           CW   = 8
) (
  input  logic                clk,
  input  logic                rst,
  powlib_edge_decode_if.slave ev
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (&c) return c;
    else    return c + CW'(1);
  endfunction

  logic          acc_p0;
  logic [W-1:0]  viol_p0;
  logic [W-1:0]  q_nxt_p0;

  logic [W-1:0]  q_p1;
  logic          vld_p1;
  logic [W-1:0]  err_p1;
  logic [W-1:0]  sticky_p1;
  logic [CW-1:0] cnt_p1;

  // ---- stage p0: sample qualification, next level and violation detect ----
  always_comb begin
    acc_p0   = EVLD ? ev.vld : 1'b1;
    viol_p0  = '0;
    q_nxt_p0 = q_p1;
    for (int i = 0; i < W; i++) begin
      unique case ({ev.pos[i], ev.neg[i]})
        2'b10: begin
          q_nxt_p0[i] = 1'b1;
          viol_p0[i]  = q_p1[i];
        end
        2'b01: begin
          q_nxt_p0[i] = 1'b0;
          viol_p0[i]  = ~q_p1[i];
        end
        // Simultaneous rise and fall: ambiguous, so the level holds.
        2'b11:   viol_p0[i] = 1'b1;
        default: ;
      endcase
    end
    if (!EERR) viol_p0 = '0;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_p1      <= INIT;
      vld_p1    <= 1'b0;
      err_p1    <= '0;
      sticky_p1 <= '0;
      cnt_p1    <= '0;
    end else begin
      vld_p1 <= acc_p0;
      err_p1 <= acc_p0 ? viol_p0 : '0;
      if (acc_p0) q_p1 <= q_nxt_p0;
      // clr wins over a coincident violation: it still pulses err but is
      // neither stuck nor counted.
      if (ev.clr) begin
        sticky_p1 <= '0;
        cnt_p1    <= '0;
      end else if (acc_p0) begin
        sticky_p1 <= sticky_p1 | viol_p0;
        if (|viol_p0) cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign ev.q          = q_p1;
  assign ev.qvld       = vld_p1;
  assign ev.err        = err_p1;
  assign ev.err_sticky = sticky_p1;
  assign ev.errcnt     = cnt_p1;

endmodule

// File: tb/tb_powlib_edge_decode.sv
module tb_powlib_edge_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  powlib_edge_decode_if #(.W(4), .CW(8)) ifa ();
  powlib_edge_decode_if #(.W(4), .CW(8)) ife ();
  powlib_edge_decode_if #(.W(4), .CW(2)) ifb ();
  powlib_edge_decode_if #(.W(7), .CW(8)) ifd ();

  // Basic decoder, always sampling.
  powlib_edge_decode #(.W(4), .INIT(4'h0), .EVLD(1'b0), .EERR(1'b1), .CW(8))
    u_a (.clk(clk), .rst(rst), .ev(ifa));
  // Same stimulus as u_a, violation logic removed.
  powlib_edge_decode #(.W(4), .INIT(4'h0), .EVLD(1'b0), .EERR(1'b0), .CW(8))
    u_e (.clk(clk), .rst(rst), .ev(ife));
  // vld-qualified, narrow saturating counter.
  powlib_edge_decode #(.W(4), .INIT(4'h0), .EVLD(1'b1), .EERR(1'b1), .CW(2))
    u_b (.clk(clk), .rst(rst), .ev(ifb));
  // Non-zero reset pattern.
  powlib_edge_decode #(.W(7), .INIT(7'h55), .EVLD(1'b0), .EERR(1'b1), .CW(8))
    u_d (.clk(clk), .rst(rst), .ev(ifd));

  assign ife.pos = ifa.pos;
  assign ife.neg = ifa.neg;
  assign ife.vld = ifa.vld;
  assign ife.clr = ifa.clr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.pos = '0; ifa.neg = '0; ifa.vld = 1'b0; ifa.clr = 1'b0;
    ifb.pos = '0; ifb.neg = '0; ifb.vld = 1'b0; ifb.clr = 1'b0;
    ifd.pos = '0; ifd.neg = '0; ifd.vld = 1'b0; ifd.clr = 1'b0;

    // Reset state
    tick();
    check("rst_a_q",      32'(ifa.q),      32'h0);
    check("rst_a_qvld",   32'(ifa.qvld),   32'h0);
    check("rst_a_err",    32'(ifa.err),    32'h0);
    check("rst_a_errcnt", 32'(ifa.errcnt), 32'h0);
    check("rst_d_q",      32'(ifd.q),      32'h55);
    #3 rst = 1'b1;
    tick();
    check("a_qvld_after_rst", 32'(ifa.qvld), 32'h1);

    // Plain rise then fall
    ifa.pos = 4'b0001; tick();
    check("a_rise_q",   32'(ifa.q),   32'h1);
    check("a_rise_err", 32'(ifa.err), 32'h0);
    ifa.pos = 4'b0000; ifa.neg = 4'b0001; tick();
    check("a_fall_q",   32'(ifa.q),   32'h0);
    check("a_fall_err", 32'(ifa.err), 32'h0);
    ifa.neg = 4'b0000;

    // Double rise on bit 1
    ifa.pos = 4'b0010; tick();
    check("a_pos1_q",   32'(ifa.q),   32'h2);
    check("a_pos1_err", 32'(ifa.err), 32'h0);
    tick();
    check("a_pos2_q",      32'(ifa.q),          32'h2);
    check("a_pos2_err",    32'(ifa.err),        32'h2);
    check("a_pos2_errcnt", 32'(ifa.errcnt),     32'h1);
    check("a_pos2_sticky", 32'(ifa.err_sticky), 32'h2);
    check("e_pos2_q",      32'(ife.q),          32'h2);
    check("e_pos2_err",    32'(ife.err),        32'h0);
    check("e_pos2_errcnt", 32'(ife.errcnt),     32'h0);
    ifa.pos = 4'b0000; tick();
    check("a_idle_err",    32'(ifa.err),    32'h0);
    check("a_idle_errcnt", 32'(ifa.errcnt), 32'h1);

    // Clear, then bring q back to 0000
    ifa.clr = 1'b1; tick();
    check("a_clr_errcnt", 32'(ifa.errcnt),     32'h0);
    check("a_clr_sticky", 32'(ifa.err_sticky), 32'h0);
    check("a_clr_q",      32'(ifa.q),          32'h2);
    ifa.clr = 1'b0; ifa.neg = 4'b0010; tick();
    check("a_neg1_q", 32'(ifa.q), 32'h0);

    // Rise and fall together on bit 3
    ifa.neg = 4'b1000; ifa.pos = 4'b1000; tick();
    check("a_both_q",      32'(ifa.q),      32'h0);
    check("a_both_err",    32'(ifa.err),    32'h8);
    check("a_both_errcnt", 32'(ifa.errcnt), 32'h1);

    // Fall while already low on bit 2
    ifa.pos = 4'b0000; ifa.neg = 4'b0100; tick();
    check("a_fall_low_q",      32'(ifa.q),          32'h0);
    check("a_fall_low_err",    32'(ifa.err),        32'h4);
    check("a_fall_low_errcnt", 32'(ifa.errcnt),     32'h2);
    check("a_fall_low_sticky", 32'(ifa.err_sticky), 32'hC);

    // clr coincident with a violation: err pulses, nothing counted
    ifa.clr = 1'b1; tick();
    check("a_clrv_err",    32'(ifa.err),        32'h4);
    check("a_clrv_errcnt", 32'(ifa.errcnt),     32'h0);
    check("a_clrv_sticky", 32'(ifa.err_sticky), 32'h0);
    ifa.clr = 1'b0; ifa.neg = 4'b0000;

    // Qualified sampling
    ifb.pos = 4'b0100; ifb.vld = 1'b0; tick();
    check("b_novld_q",    32'(ifb.q),    32'h0);
    check("b_novld_qvld", 32'(ifb.qvld), 32'h0);
    ifb.vld = 1'b1; tick();
    check("b_vld_q",    32'(ifb.q),    32'h4);
    check("b_vld_qvld", 32'(ifb.qvld), 32'h1);

    // Five violating cycles into a 2-bit saturating counter
    for (int k = 0; k < 5; k++) begin
      tick();
      check("b_sat_err",    32'(ifb.err),    32'h4);
      check("b_sat_errcnt", 32'(ifb.errcnt), (k < 3) ? 32'(k + 1) : 32'h3);
    end
    ifb.vld = 1'b0; tick();
    check("b_hold_err",    32'(ifb.err),    32'h0);
    check("b_hold_errcnt", 32'(ifb.errcnt), 32'h3);
    check("b_hold_qvld",   32'(ifb.qvld),   32'h0);
    ifb.pos = 4'b0000; ifb.clr = 1'b1; tick();
    check("b_clr_errcnt", 32'(ifb.errcnt),     32'h0);
    check("b_clr_sticky", 32'(ifb.err_sticky), 32'h0);
    check("b_clr_q",      32'(ifb.q),          32'h4);
    ifb.clr = 1'b0;

    // Non-zero INIT, then reset mid-stream
    ifd.pos = 7'h02; tick();
    check("d_rise_q", 32'(ifd.q), 32'h57);
    ifd.pos = 7'h00; ifd.neg = 7'h01; tick();
    check("d_fall_q", 32'(ifd.q), 32'h56);
    ifd.neg = 7'h00; ifd.pos = 7'h04; tick();
    check("d_viol_err",    32'(ifd.err),    32'h4);
    check("d_viol_errcnt", 32'(ifd.errcnt), 32'h1);
    ifd.pos = 7'h08;
    #3 rst = 1'b0;
    #1;
    check("d_mid_rst_q",      32'(ifd.q),      32'h55);
    check("d_mid_rst_errcnt", 32'(ifd.errcnt), 32'h0);
    check("d_mid_rst_qvld",   32'(ifd.qvld),   32'h0);
    check("d_mid_rst_err",    32'(ifd.err),    32'h0);
    #2;
    rst = 1'b1;
    ifd.pos = 7'h00;
    tick();
    check("d_post_rst_q",    32'(ifd.q),    32'h55);
    check("d_post_rst_err",  32'(ifd.err),  32'h0);
    check("d_post_rst_qvld", 32'(ifd.qvld), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
